// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch-stage PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// and a simultaneous push+pop replaces the top entry in place.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_en;

  assign pop_en = pop_i && (cnt_q != '0);

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_ptr = top_q + 1'b1;
    if (push_i && pop_en) begin
      wr_ptr = top_q;
    end else if (push_i) begin
      top_d = top_q + 1'b1;
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop_en) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; only the count is cleared.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr] <= push_data_i;
  end

  assign top_o   = mem_q[top_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects and a fetch handshake.
// Optional return-address stack built when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            if_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] epc_o,
  input  logic            call_i,
  input  logic [XLEN-1:0] call_ret_addr_i,
  input  logic            ret_i,
  output logic            ras_empty_o
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ret_take, take_any;

  assign ret_take = ret_i && !ras_empty && !(trap_i || mret_i || redirect_i);
  assign take_any = trap_i || mret_i || redirect_i || ret_take;

`ifdef PC_GEN_RAS_EN
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (call_i),
    .push_data_i (call_ret_addr_i),
    .pop_i       (ret_take),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{call_i, call_ret_addr_i, RAS_DEPTH[0]};
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (take_any) state_d = FLUSH;
    else          state_d = FETCH;
  end

  always_comb begin
    if_valid_o = (state_q == FETCH);
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (trap_i) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (mret_i) begin
      pc_d = epc_q;
    end else if (redirect_i) begin
      pc_d = redirect_target_i & ALIGN_MASK;
    end else if (ret_take) begin
      pc_d = ras_top;
    end else if (state_q == FETCH && if_ready_i && !stall_i) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus_o   = pc_q + STEP;
  assign epc_o       = epc_q;
  assign ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus queues expected post-edge outputs,
// a monitor pops and compares them one time unit after each rising edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, if_ready_i, if_valid_o;
  logic [31:0] pc_o, pc_plus_o, epc_o;
  logic        redirect_i, trap_i, mret_i, call_i, ret_i, ras_empty_o;
  logic [31:0] redirect_target_i, call_ret_addr_i;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        empty;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_epc = 32'h0;

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (32'h100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .if_ready_i       (if_ready_i),
    .if_valid_o       (if_valid_o),
    .pc_o             (pc_o),
    .pc_plus_o        (pc_plus_o),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .trap_i           (trap_i),
    .mret_i           (mret_i),
    .epc_o            (epc_o),
    .call_i           (call_i),
    .call_ret_addr_i  (call_ret_addr_i),
    .ret_i            (ret_i),
    .ras_empty_o      (ras_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
    else n_pass++;
  endtask

  // Monitor: every queued expectation describes the outputs after one rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "pc",      pc_o,              e.pc);
      chk(e.name, "pc_plus", pc_plus_o,         e.pc + 32'd4);
      chk(e.name, "valid",   {31'd0, if_valid_o}, {31'd0, e.valid});
      chk(e.name, "epc",     epc_o,             e.epc);
      chk(e.name, "empty",   {31'd0, ras_empty_o}, {31'd0, e.empty});
    end
  end

  // Inputs are set by the caller right after a falling edge; one cycle is run.
  task automatic cyc(input string nm, input logic [31:0] pc, input logic v, input logic emp);
    exp_t e;
    e.name = nm; e.pc = pc; e.valid = v; e.epc = exp_epc; e.empty = emp;
    sb_q.push_back(e);
    @(negedge clk);
    redirect_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; if_ready_i = 1'b1;
    redirect_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
    redirect_target_i = '0; call_ret_addr_i = '0;
    @(negedge clk);

    cyc("reset", 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc("boot", 32'h0, 1'b1, 1'b1);
    cyc("seq4", 32'h4, 1'b1, 1'b1);
    cyc("seq8", 32'h8, 1'b1, 1'b1);

    if_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc("notready", 32'h8, 1'b1, 1'b1);
    if_ready_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) cyc("stall", 32'h8, 1'b1, 1'b1);
    stall_i = 1'b0;
    cyc("release", 32'hC, 1'b1, 1'b1);

    redirect_i = 1'b1; redirect_target_i = 32'h40;
    cyc("redir40", 32'h40, 1'b0, 1'b1);
    cyc("redir40_fetch", 32'h40, 1'b1, 1'b1);

    trap_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h203; ret_i = 1'b1;
    exp_epc = 32'h40;
    cyc("trap_prio", 32'h100, 1'b0, 1'b1);
    if_ready_i = 1'b0;
    cyc("trap_fetch", 32'h100, 1'b1, 1'b1);
    mret_i = 1'b1;
    cyc("mret", 32'h40, 1'b0, 1'b1);
    if_ready_i = 1'b1;
    cyc("mret_fetch", 32'h40, 1'b1, 1'b1);
    cyc("mret_seq", 32'h44, 1'b1, 1'b1);

    redirect_i = 1'b1; redirect_target_i = 32'h203;
    cyc("redir_align", 32'h200, 1'b0, 1'b1);
    cyc("align_fetch", 32'h200, 1'b1, 1'b1);
    cyc("align_seq", 32'h204, 1'b1, 1'b1);

    if_ready_i = 1'b0; stall_i = 1'b1;
    redirect_i = 1'b1; redirect_target_i = 32'h80;
    cyc("redir_stall", 32'h80, 1'b0, 1'b1);
    cyc("stall_fetch", 32'h80, 1'b1, 1'b1);
    cyc("stall_hold", 32'h80, 1'b1, 1'b1);
    if_ready_i = 1'b1; stall_i = 1'b0;

    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    cyc("redir_top", 32'hFFFF_FFFC, 1'b0, 1'b1);
    cyc("top_fetch", 32'hFFFF_FFFC, 1'b1, 1'b1);
    cyc("wrap", 32'h0, 1'b1, 1'b1);

    if_ready_i = 1'b0;
`ifdef PC_GEN_RAS_EN
    call_i = 1'b1; call_ret_addr_i = 32'h10; cyc("push10", 32'h0, 1'b1, 1'b0);
    call_i = 1'b1; call_ret_addr_i = 32'h20; cyc("push20", 32'h0, 1'b1, 1'b0);
    call_i = 1'b1; call_ret_addr_i = 32'h30; cyc("push30", 32'h0, 1'b1, 1'b0);
    call_i = 1'b1; call_ret_addr_i = 32'h40; cyc("push40", 32'h0, 1'b1, 1'b0);
    call_i = 1'b1; call_ret_addr_i = 32'h50; cyc("push50", 32'h0, 1'b1, 1'b0);
    ret_i = 1'b1; cyc("pop50", 32'h50, 1'b0, 1'b0);
    ret_i = 1'b1; cyc("pop40", 32'h40, 1'b0, 1'b0);
    ret_i = 1'b1; cyc("pop30", 32'h30, 1'b0, 1'b0);
    ret_i = 1'b1; cyc("pop20", 32'h20, 1'b0, 1'b1);
    ret_i = 1'b1; cyc("ret_empty", 32'h20, 1'b1, 1'b1);
    call_i = 1'b1; call_ret_addr_i = 32'h20; cyc("push20b", 32'h20, 1'b1, 1'b0);
    call_i = 1'b1; call_ret_addr_i = 32'h90; ret_i = 1'b1;
    cyc("call_ret", 32'h20, 1'b0, 1'b0);
    ret_i = 1'b1; cyc("pop90", 32'h90, 1'b0, 1'b1);
    call_i = 1'b1; call_ret_addr_i = 32'h30; cyc("push30b", 32'h90, 1'b1, 1'b0);
    redirect_i = 1'b1; redirect_target_i = 32'h300; ret_i = 1'b1;
    cyc("ret_loses", 32'h300, 1'b0, 1'b0);
    ret_i = 1'b1; cyc("pop30b", 32'h30, 1'b0, 1'b1);
    cyc("idle", 32'h30, 1'b1, 1'b1);
`else
    ret_i = 1'b1; cyc("ret_ignored", 32'h0, 1'b1, 1'b1);
    call_i = 1'b1; call_ret_addr_i = 32'h10; cyc("call_ignored", 32'h0, 1'b1, 1'b1);
    ret_i = 1'b1; cyc("ret_after_call", 32'h0, 1'b1, 1'b1);
`endif

    if_ready_i = 1'b1; reset = 1'b1; exp_epc = 32'h0;
    cyc("mid_reset", 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc("reboot", 32'h0, 1'b1, 1'b1);
    cyc("reboot_seq", 32'h4, 1'b1, 1'b1);

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
